// File: rtl/mac_accum_seq.sv
// Accumulate-stage sequencer: owns the accumulator register, feeds the external
// adder and returns the sum plus a sticky overflow flag over valid/ready.
module mac_accum_seq #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [ACC_W-1:0] in_data,
  output logic             in_ready,
  output logic [ACC_W-1:0] add_a,
  output logic [ACC_W-1:0] add_b,
  input  logic [ACC_W-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic             SAT_EN   = (SAT != 32'sd0);
  localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
  localparam logic [ACC_W-1:0] ACC_ONES = {ACC_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [ACC_W-1:0] acc_r, acc_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             ovf_r, ovf_s;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= ACC_ZERO;
      cnt_r   <= CNT_ZERO;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      ovf_r   <= ovf_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s = state_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    ovf_s   = ovf_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          acc_s = ACC_ZERO;
          ovf_s = 1'b0;
          if (len != CNT_ZERO) begin
            cnt_s   = len;
            state_s = ACC;
          end else begin
            cnt_s   = CNT_ZERO;
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (in_valid) begin
          cnt_s = cnt_r - CNT_ONE;
          // Carry is trusted from the adder; with SAT the clamp also pins
          // a saturated accumulator, since any nonzero term then carries.
          if (add_cout) begin
            ovf_s = 1'b1;
            acc_s = SAT_EN ? ACC_ONES : add_sum;
          end else begin
            acc_s = add_sum;
          end
          if (cnt_r == CNT_ONE) begin
            state_s = DONE;
          end else begin
            state_s = ACC;
          end
        end else begin
          state_s = ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Handshake flags decode straight from the state register
  assign in_ready  = (state_r == ACC);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign out_acc   = acc_r;
  assign out_ovf   = ovf_r;
  assign add_a     = acc_r;
  // Operand B held at zero outside ACC to keep the adder quiet
  assign add_b     = in_ready ? in_data : ACC_ZERO;

endmodule

// File: tb/tb_mac_accum_seq.sv
// Directed bench: a wrap (SAT=0) and a clamp (SAT=1) instance share stimulus,
// each with its own behavioural adder; vectors plus hand-written corner cases.
module tb_mac_accum_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [23:0] in_data;
  logic        out_ready;

  logic        in_ready0, out_valid0, out_ovf0, busy0, cout0;
  logic [23:0] add_a0, add_b0, sum0, out_acc0;
  logic        in_ready1, out_valid1, out_ovf1, busy1, cout1;
  logic [23:0] add_a1, add_b1, sum1, out_acc1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  assign {cout0, sum0} = {1'b0, add_a0} + {1'b0, add_b0};
  assign {cout1, sum1} = {1'b0, add_a1} + {1'b0, add_b1};

  mac_accum_seq #(.ACC_W(24), .CNT_W(8), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .add_a(add_a0), .add_b(add_b0), .add_sum(sum0), .add_cout(cout0),
    .out_valid(out_valid0), .out_acc(out_acc0), .out_ovf(out_ovf0),
    .out_ready(out_ready), .busy(busy0)
  );

  mac_accum_seq #(.ACC_W(24), .CNT_W(8), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .add_a(add_a1), .add_b(add_b1), .add_sum(sum1), .add_cout(cout1),
    .out_valid(out_valid1), .out_acc(out_acc1), .out_ovf(out_ovf1),
    .out_ready(out_ready), .busy(busy1)
  );

  typedef struct {
    int          len;
    logic [23:0] t [5];
    logic [23:0] mid0, mid1;
    logic [23:0] acc0, acc1;
    logic        ovf0, ovf1;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i, input int l,
                         input logic [23:0] a, input logic [23:0] b, input logic [23:0] c,
                         input logic [23:0] d, input logic [23:0] e,
                         input logic [23:0] m0, input logic [23:0] m1,
                         input logic [23:0] r0, input logic o0,
                         input logic [23:0] r1, input logic o1);
    vecs[i].len = l;
    vecs[i].t[0] = a; vecs[i].t[1] = b; vecs[i].t[2] = c;
    vecs[i].t[3] = d; vecs[i].t[4] = e;
    vecs[i].mid0 = m0; vecs[i].mid1 = m1;
    vecs[i].acc0 = r0; vecs[i].ovf0 = o0;
    vecs[i].acc1 = r1; vecs[i].ovf1 = o1;
  endtask

  task automatic run_vec(input int v);
    start = 1'b1;
    len   = vecs[v].len[7:0];
    step();
    start = 1'b0;
    chk($sformatf("v%0d in_ready", v), {31'd0, in_ready0 & in_ready1}, 32'd1);
    for (int i = 0; i < vecs[v].len; i++) begin
      in_valid = 1'b1;
      in_data  = vecs[v].t[i];
      step();
      if (i == 1) begin
        chk($sformatf("v%0d mid acc0", v), {8'd0, add_a0}, {8'd0, vecs[v].mid0});
        chk($sformatf("v%0d mid acc1", v), {8'd0, add_a1}, {8'd0, vecs[v].mid1});
      end
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d out_valid", v), {30'd0, out_valid0, out_valid1}, 32'd3);
    chk($sformatf("v%0d acc0", v), {8'd0, out_acc0}, {8'd0, vecs[v].acc0});
    chk($sformatf("v%0d ovf0", v), {31'd0, out_ovf0}, {31'd0, vecs[v].ovf0});
    chk($sformatf("v%0d acc1", v), {8'd0, out_acc1}, {8'd0, vecs[v].acc1});
    chk($sformatf("v%0d ovf1", v), {31'd0, out_ovf1}, {31'd0, vecs[v].ovf1});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk($sformatf("v%0d idle", v), {30'd0, busy0, busy1}, 32'd0);
  endtask

  initial begin
    set_vec(0, 3, 24'h000010, 24'h000020, 24'h000030, 24'h0, 24'h0,
            24'h000030, 24'h000030, 24'h000060, 1'b0, 24'h000060, 1'b0);
    set_vec(1, 2, 24'hFFFFF0, 24'h000020, 24'h0, 24'h0, 24'h0,
            24'h000010, 24'hFFFFFF, 24'h000010, 1'b1, 24'hFFFFFF, 1'b1);
    set_vec(2, 3, 24'hFFFFF0, 24'h000020, 24'h000001, 24'h0, 24'h0,
            24'h000010, 24'hFFFFFF, 24'h000011, 1'b1, 24'hFFFFFF, 1'b1);
    set_vec(3, 1, 24'h000007, 24'h0, 24'h0, 24'h0, 24'h0,
            24'h0, 24'h0, 24'h000007, 1'b0, 24'h000007, 1'b0);
    set_vec(4, 2, 24'hFFFFFF, 24'h000000, 24'h0, 24'h0, 24'h0,
            24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 24'hFFFFFF, 1'b0);
    set_vec(5, 5, 24'h800000, 24'h800000, 24'h000001, 24'h000002, 24'h000003,
            24'h000000, 24'hFFFFFF, 24'h000006, 1'b1, 24'hFFFFFF, 1'b1);

    rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    in_data = 24'h0; out_ready = 1'b0;
    #12;
    chk("rst busy", {31'd0, busy0}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready0}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid0}, 32'd0);
    chk("rst out_acc", {8'd0, out_acc0}, 32'd0);
    chk("rst out_ovf", {31'd0, out_ovf0}, 32'd0);
    chk("rst add_a", {8'd0, add_a0}, 32'd0);
    in_data = 24'h123456;
    #1;
    chk("idle add_b", {8'd0, add_b0}, 32'd0);
    in_data = 24'h0;
    rst = 1'b0;
    step();

    for (int v = 0; v < 6; v++) run_vec(v);

    // len=0 goes straight to DONE and clears the previous run's ovf
    start = 1'b1; len = 8'd0;
    step();
    start = 1'b0;
    chk("len0 out_valid", {31'd0, out_valid0}, 32'd1);
    chk("len0 out_acc", {8'd0, out_acc1}, 32'd0);
    chk("len0 out_ovf", {30'd0, out_ovf0, out_ovf1}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("len0 idle", {31'd0, busy0}, 32'd0);

    // Stalls on alternate cycles: 7 cycles for 4 accepts
    start = 1'b1; len = 8'd4;
    step();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("stall in_ready c%0d", k), {31'd0, in_ready0}, 32'd1);
      chk($sformatf("stall out_valid c%0d", k), {31'd0, out_valid0}, 32'd0);
      in_valid = (k % 2 == 0);
      in_data  = 24'h000001;
      step();
    end
    in_valid = 1'b0;
    chk("stall out_valid", {31'd0, out_valid0}, 32'd1);
    chk("stall out_acc", {8'd0, out_acc0}, 32'd4);
    // Backpressure with a stray start during DONE
    for (int k = 0; k < 5; k++) begin
      start = (k == 2);
      len   = 8'd9;
      step();
      chk($sformatf("hold out_valid c%0d", k), {31'd0, out_valid0}, 32'd1);
      chk($sformatf("hold out_acc c%0d", k), {8'd0, out_acc0}, 32'd4);
      chk($sformatf("hold in_ready c%0d", k), {31'd0, in_ready0}, 32'd0);
    end
    // start in the handshake cycle is ignored
    start = 1'b1; len = 8'd1; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    chk("handshake start ignored", {31'd0, busy0}, 32'd0);

    // start during ACC must not reload cnt or clear acc
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 24'h000005;
    step();
    in_valid = 1'b0; start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    step();
    chk("busy start no early done", {31'd0, out_valid0}, 32'd0);
    step();
    in_valid = 1'b0;
    chk("busy start out_valid", {31'd0, out_valid0}, 32'd1);
    chk("busy start out_acc", {8'd0, out_acc0}, 32'd15);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset between edges after 2 of 5 terms
    start = 1'b1; len = 8'd5;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 24'h000003;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst busy", {30'd0, busy0, busy1}, 32'd0);
    chk("arst in_ready", {30'd0, in_ready0, in_ready1}, 32'd0);
    chk("arst out_valid", {30'd0, out_valid0, out_valid1}, 32'd0);
    chk("arst acc", {8'd0, add_a0}, 32'd0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    step();
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_data = 24'h000007;
    step();
    in_valid = 1'b0;
    chk("post rst out_valid", {31'd0, out_valid0}, 32'd1);
    chk("post rst acc0", {8'd0, out_acc0}, 32'd7);
    chk("post rst acc1", {8'd0, out_acc1}, 32'd7);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mac_accum_seq.md
# mac_accum_seq

Sequencer for the MAC accumulate stage. It owns the 24-bit accumulator register and drives the external 24-bit Kogge-Stone adder's operands. It accepts a programmed number of addend terms over a valid/ready stream, one per cycle. It returns the final sum plus an overflow flag over a second valid/ready handshake.

## Interface
- ACC_W, 24, accumulator and adder width; must match the external adder.
- CNT_W, 8, width of the term-count field.
- SAT, 0, overflow policy: 0 = wrap and set sticky flag; 1 = clamp accumulator to all-ones and set sticky flag.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a new accumulation; sampled only in IDLE.
- len  in  CNT_W  number of terms; captured with start.
- in_valid  in  1  addend term valid.
- in_data  in  ACC_W  addend term (unsigned).
- in_ready  out  1  term accepted when in_valid & in_ready.
- add_a  out  ACC_W  adder operand A = accumulator register.
- add_b  out  ACC_W  adder operand B = in_data in ACC state, else 0.
- add_sum  in  ACC_W  combinational sum from the external adder.
- add_cout  in  1  combinational carry-out from the external adder.
- out_valid  out  1  result available.
- out_acc  out  ACC_W  final accumulator value.
- out_ovf  out  1  at least one carry-out occurred during the run.
- out_ready  in  1  result consumed when out_valid & out_ready.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACC, DONE.
- IDLE: in_ready=0, out_valid=0.
  - On start with len≠0: acc←0, ovf←0, cnt←len, go to ACC.
  - On start with len=0: acc←0, ovf←0, go directly to DONE.
- ACC: in_ready=1.
  - On each accepted term: acc←add_sum and cnt←cnt−1.
  - If add_cout=1 on that term: ovf←1. With SAT=1, acc←all-ones instead of add_sum.
  - With SAT=1, once acc is all-ones, further terms keep it all-ones. Any nonzero term then produces a carry, and ovf stays 1.
  - Accepting the term with cnt=1 moves to DONE.
  - in_valid low stalls with no state change.
- DONE: out_valid=1; out_acc=acc; out_ovf=ovf.
  - Outputs are held stable until out_ready=1, then go to IDLE.
  - in_ready=0 in this state.
- start is ignored outside IDLE; len is not re-sampled mid-run.
- Arithmetic is unsigned modulo 2^ACC_W. Carry-out is taken only from add_cout; nothing is recomputed internally.
- add_b is forced to 0 outside ACC so the adder does not toggle (low-power requirement).

## Timing
- Reset (async assert, sync-to-clk deassert usage):
  - state=IDLE, acc=0, cnt=0, ovf=0.
  - in_ready=0, out_valid=0, out_acc=0, out_ovf=0, busy=0, add_a=0, add_b=0.
- Reset asserted mid-run aborts the run immediately. No out_valid is produced for the aborted run.
- start→ACC: in_ready rises the cycle after start is sampled.
- Throughput: one term per cycle while in_valid=1.
- Latency: out_valid rises the cycle after the last term is accepted.
- len=0: out_valid rises the cycle after start.
- out_valid & out_ready → IDLE next cycle.
- A start in that same cycle is ignored, because the state is not IDLE. The earliest new start is sampled one cycle after the handshake.
- Back-to-back minimum period per run: len + 2 cycles (start cycle, len term cycles, one DONE cycle with out_ready=1).
- in_ready depends only on state, never combinationally on in_valid. out_valid likewise depends only on state.

## Test plan
- Basic sum: SAT=0, len=3, terms 0x000010, 0x000020, 0x000030 back-to-back, out_ready=1.
  - Expect out_valid 1 cycle after the 3rd accept, out_acc=0x000060, out_ovf=0.
  - Total 5 cycles from start to return to IDLE.
- Wrap overflow: SAT=0, len=2, terms 0xFFFFF0 and 0x000020.
  - Expect out_acc=0x000010, out_ovf=1.
- Saturation: SAT=1, len=3, terms 0xFFFFF0, 0x000020, 0x000001.
  - Expect acc clamped to 0xFFFFFF after the 2nd term.
  - Expect out_acc=0xFFFFFF, out_ovf=1.
- Stalls and backpressure: len=4, terms of 1 with in_valid toggling 1,0,1,0…
  - Expect in_ready held 1 and exactly 4 accepts, out_acc=0x000004.
  - Hold out_ready=0 for 5 cycles: out_valid and out_acc stay stable, and a start pulse during DONE is ignored.
- len=0 and start while busy:
  - start with len=0 gives out_valid next cycle, out_acc=0, out_ovf=0.
  - start asserted during ACC does not alter cnt or acc.
- Async reset mid-run: assert rst between clock edges after 2 of 5 terms.
  - Expect busy=0, in_ready=0, out_valid=0 immediately.
  - The next run with len=1 and term 0x000007 yields out_acc=0x000007.
